// File: rtl/imm_ext.sv
// Immediate extender: one registered stage with a valid/ready handshake between decode and execute.
// Defining EXT_BYPASS_EN turns the block into a purely combinational extender with zero latency.

package imm_ext_pkg;

   typedef enum logic [1:0] {
      EOP_SEXT = 2'b00,  // sign extend
      EOP_ZEXT = 2'b01,  // zero extend
      EOP_LUI  = 2'b10,  // load into upper half
      EOP_BR   = 2'b11   // sign extend, then shift left by 2 (branch word offset)
   } eop_e;

   function automatic logic [31:0] extend(input logic [15:0] imm, input eop_e op);
      logic [31:0] r;
      // NOTE: give every combinational result a default first so no path can infer a latch.
      r = '0;
      case (op)
         EOP_SEXT: r = {{16{imm[15]}}, imm};
         EOP_ZEXT: r = {16'h0000, imm};
         EOP_LUI:  r = {imm, 16'h0000};
         EOP_BR:   r = {{14{imm[15]}}, imm, 2'b00};
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

module imm_ext
   import imm_ext_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] imm,
   input  logic [1:0]  EOp,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] ext,
   output logic        out_valid,
   input  logic        out_ready
);

   logic [31:0] ext_next;
   assign ext_next = extend(imm, eop_e'(EOp));

`ifdef EXT_BYPASS_EN

   // Clock and reset have no function here; tie them off into a deliberately unused net.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   assign ext       = ext_next;
   assign out_valid = in_valid;
   assign in_ready  = out_ready;

`else

   logic [31:0] ext_q;
   logic        valid_q;
   logic        accept;

   // The stage is free when empty or when its current result leaves this cycle.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q   <= '0;
         valid_q <= 1'b0;
      end else if (accept) begin
         ext_q   <= ext_next;
         valid_q <= 1'b1;
      end else if (out_ready) begin
         valid_q <= 1'b0;   // ext_q deliberately keeps its last value
      end
   end

   assign ext       = ext_q;
   assign out_valid = valid_q;

`endif

endmodule

// File: tb/tb_imm_ext.sv
// Self-checking bench for imm_ext: directed vectors plus randomized traffic against a behavioural model.
// Builds with or without EXT_BYPASS_EN and checks the matching behaviour.

module tb_imm_ext;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] imm;
   logic [1:0]  EOp;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ext;
   logic        out_valid;
   logic        out_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: what the stage should be holding.
   logic        exp_valid = 1'b0;
   logic [31:0] exp_ext   = '0;

   imm_ext dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imm       (imm),
      .EOp       (EOp),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ext       (ext),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Extension rules evaluated arithmetically on integers.
   function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] op);
      int s;
      int u;
      s = int'($signed(v));
      u = int'(v);
      case (op)
         2'd0:    return 32'(s);
         2'd1:    return 32'(u);
         2'd2:    return 32'(u * 65536);
         default: return 32'(s * 4);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

`ifndef EXT_BYPASS_EN
   // Drive one cycle of stimulus, check in_ready before the edge and outputs after it.
   task automatic step(input logic v, input logic [15:0] i, input logic [1:0] e, input logic r);
      logic exp_rdy;
      in_valid  = v;
      imm       = i;
      EOp       = e;
      out_ready = r;
      #1;
      exp_rdy = !exp_valid || r;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (v && exp_rdy) begin
         exp_valid = 1'b1;
         exp_ext   = ref_ext(i, e);
      end else if (r) begin
         exp_valid = 1'b0;
      end
      #1;
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("ext", ext, exp_ext);
   endtask

   task automatic pulse_reset();
      #3 rst_n = 1'b0;
      #1;
      exp_valid = 1'b0;
      exp_ext   = '0;
      check("rst_ext", ext, 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      logic [31:0] vec_a [4];
      logic [31:0] vec_b [4];
      logic [31:0] held;
      vec_a = '{32'h000001f2, 32'h000001f2, 32'h01f20000, 32'h000007c8};
      vec_b = '{32'hffff8001, 32'h00008001, 32'h80010000, 32'hfffe0004};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      imm       = '0;
      EOp       = '0;
      out_ready = 1'b0;

`ifdef EXT_BYPASS_EN
      #2;
      imm = 16'h01f2; EOp = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      check("byp_ext", ext, 32'h000007c8);
      check("byp_out_valid", 32'(out_valid), 32'h1);
      check("byp_in_ready", 32'(in_ready), 32'h0);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("byp_out_valid_low", 32'(out_valid), 32'h0);
      check("byp_in_ready_high", 32'(in_ready), 32'h1);
      for (int k = 0; k < 4; k++) begin
         imm = 16'h8001; EOp = 2'(k);
         #1;
         check("byp_vec_8001", ext, vec_b[k]);
      end
      for (int k = 0; k < 100; k++) begin
         imm       = 16'($urandom);
         EOp       = 2'($urandom);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         #1;
         check("byp_rand_ext", ext, ref_ext(imm, EOp));
         check("byp_rand_out_valid", 32'(out_valid), 32'(in_valid));
         check("byp_rand_in_ready", 32'(in_ready), 32'(out_ready));
      end
`else
      // Reset held from time zero.
      #2;
      check("rst_ext", ext, 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, each visible one cycle after acceptance.
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 16'h01f2, 2'(k), 1'b1);
         check("vec_01f2", ext, vec_a[k]);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 16'h8001, 2'(k), 1'b1);
         check("vec_8001", ext, vec_b[k]);
      end

      // Reset mid-transfer discards the pending result.
      pulse_reset();
      step(1'b1, 16'h7fff, 2'b11, 1'b0);
      check("post_reset_accept", ext, 32'h0001fffc);
      pulse_reset();

      // Backpressure: result held, inputs ignored, then same-cycle accept on release.
      step(1'b1, 16'hffff, 2'b00, 1'b0);
      check("bp_load", ext, 32'hffffffff);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 16'($urandom), 2'($urandom), 1'b0);
         check("bp_hold_ext", ext, 32'hffffffff);
         check("bp_hold_valid", 32'(out_valid), 32'h1);
      end
      step(1'b1, 16'h1234, 2'b01, 1'b1);
      check("bp_release", ext, 32'h00001234);

      // Drain: out_valid clears, ext keeps its value, idle cycles change nothing.
      step(1'b0, 16'hdead, 2'b10, 1'b1);
      check("drain_valid", 32'(out_valid), 32'h0);
      check("drain_ext", ext, 32'h00001234);
      step(1'b0, 16'hbeef, 2'b00, 1'b0);
      check("idle_ext", ext, 32'h00001234);

      // Streaming: one result per cycle, in order, out_valid never drops.
      for (int k = 0; k < 200; k++) begin
         held = 32'(k);
         step(1'b1, 16'($urandom), 2'($urandom), 1'b1);
         check("stream_valid", 32'(out_valid), 32'h1);
      end

      // Random handshake traffic.
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom), 16'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      pulse_reset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/imm_ext.md
# imm_ext

Immediate extender for the datapath decode stage. Takes a 16-bit instruction immediate and an extend opcode and produces a 32-bit operand: sign-extended, zero-extended, loaded into the upper half, or sign-extended and word-shifted for branch offsets. The block is a single registered stage with a valid/ready handshake so it can sit between decode and execute. The RTL module is `imm_ext`.

## Interface
- Parameters: none.
- Reset is asynchronous and active-low; the block uses one clock.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- imm  input  16  immediate field.
- EOp  input  2  extend opcode.
- in_valid  input  1  imm/EOp are valid this cycle.
- in_ready  output  1  stage can accept a new operand.
- ext  output  32  extended result.
- out_valid  output  1  ext holds a valid result.
- out_ready  input  1  downstream consumes ext this cycle.

## Operation
- EOp=00, sign extend: ext = {{16{imm[15]}}, imm}.
- EOp=01, zero extend: ext = {16'h0, imm}.
- EOp=10, load upper: ext = {imm, 16'h0}.
- EOp=11, sign extend then shift left 2: ext = {{14{imm[15]}}, imm, 2'b00}.
  - No bits are lost, because the 18 significant bits fit in 32.
- Results are pure functions of imm and EOp. No saturation, no flags.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready: the result is computed and captured into the ext register, and out_valid is set.
  - When out_valid && out_ready && !(in_valid && in_ready): out_valid clears. ext keeps its last value.
  - Simultaneous consume and accept: the new result replaces the old one in the same edge, and out_valid stays 1. Full throughput is one result per cycle.
  - While out_valid && !out_ready: ext and out_valid are held stable, in_ready=0, and inputs are ignored.
- in_valid=0: inputs are don't-care, and the register is not updated.

## Timing
- Reset (rst_n low, asynchronous): ext=32'h0 and out_valid=0 immediately. in_ready=1 while in reset.
- Reset released mid-transfer: the pending result is discarded. The first edge after deassertion may accept new input.
- Latency: one cycle. An operand accepted at edge N is visible on ext with out_valid=1 after edge N.
- in_ready is combinational from out_valid and out_ready. No other combinational input-to-output path exists (except in bypass mode, below).

## Configuration
- Macro: EXT_BYPASS_EN.
- Defined: the block is purely combinational.
  - ext = f(imm, EOp) continuously.
  - out_valid = in_valid and in_ready = out_ready.
  - clk and rst_n are unused, and there is zero latency.
- Undefined (default): the registered single-stage behaviour described above.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> ext=0 and out_valid=0 immediately, in_ready=1.
- imm=16'h01f2, EOp stepped 00/01/10/11 with out_ready=1 -> ext = 32'h000001f2, 32'h000001f2, 32'h01f20000, 32'h000007c8, each one cycle after acceptance.
- imm=16'h8001, EOp 00/01/10/11 -> ext = 32'hffff8001, 32'h00008001, 32'h80010000, 32'hfffe0004.
- Backpressure: accept imm=16'hffff with EOp=00, then hold out_ready=0 for 3 cycles while driving other inputs -> ext stays 32'hffffffff, out_valid=1, in_ready=0. Raise out_ready -> the next input is accepted in the same cycle.
- Streaming: in_valid=1 and out_ready=1 continuously with a new imm each cycle -> one result per cycle, in order, out_valid never drops.
- With EXT_BYPASS_EN: imm=16'h01f2, EOp=11 -> ext=32'h000007c8 in the same cycle, out_valid follows in_valid.
